// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Write-back arbiter. Owns the register-file write port and picks one
//            of ALU / LD / MDU per cycle, using fixed priority with aging.
// Revision : 1.0
// ============================================================================
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic [4:0]      rd_num,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_we,
  input  logic            halted,
  output logic            drained
);

  localparam int NSRC  = 3;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Source index 0 has the highest fixed priority.
  localparam int SRC_ALU = 0;
  localparam int SRC_LD  = 1;
  localparam int SRC_MDU = 2;

  logic [NSRC-1:0]            valid_w;
  logic [NSRC-1:0]            urgent_w;
  logic [NSRC-1:0]            pick_w;
  logic [NSRC-1:0]            grant_w;
  logic [NSRC-1:0][CNT_W-1:0] wait_q;
  logic [NSRC-1:0][CNT_W-1:0] wait_d;

  logic [4:0]      sel_rd_w;
  logic [XLEN-1:0] sel_data_w;

  logic            rd_we_q,   rd_we_d;
  logic [4:0]      rd_num_q,  rd_num_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            drained_q, drained_d;

  assign valid_w = {mdu_valid, ld_valid, alu_valid};

  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_src
      assign urgent_w[i] = valid_w[i] && (wait_q[i] == LIMIT);

      // Age only while stalled; a transfer or idle input restarts the count.
      always_comb begin
        wait_d[i] = '0;
        if (valid_w[i] && !grant_w[i]) begin
          wait_d[i] = (wait_q[i] == LIMIT) ? wait_q[i] : wait_q[i] + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Urgent requesters pre-empt everyone; ties resolve by fixed priority.
  assign pick_w = (|urgent_w) ? urgent_w : valid_w;

  always_comb begin
    grant_w = '0;
    if (pick_w[SRC_ALU]) begin
      grant_w[SRC_ALU] = 1'b1;
    end else if (pick_w[SRC_LD]) begin
      grant_w[SRC_LD] = 1'b1;
    end else if (pick_w[SRC_MDU]) begin
      grant_w[SRC_MDU] = 1'b1;
    end
  end

  assign alu_ready = grant_w[SRC_ALU];
  assign ld_ready  = grant_w[SRC_LD];
  assign mdu_ready = grant_w[SRC_MDU];

  always_comb begin
    sel_rd_w   = '0;
    sel_data_w = '0;
    unique case (1'b1)
      grant_w[SRC_ALU]: begin
        sel_rd_w   = alu_rd;
        sel_data_w = alu_data;
      end
      grant_w[SRC_LD]: begin
        sel_rd_w   = ld_rd;
        sel_data_w = ld_data;
      end
      grant_w[SRC_MDU]: begin
        sel_rd_w   = mdu_rd;
        sel_data_w = mdu_data;
      end
      default: begin
        sel_rd_w   = '0;
        sel_data_w = '0;
      end
    endcase
  end

  // r0 results are consumed but never reach the register file.
  always_comb begin
    rd_we_d   = (|grant_w) && (sel_rd_w != 5'd0);
    rd_num_d  = rd_num_q;
    rd_data_d = rd_data_q;
    if (|grant_w) begin
      rd_num_d  = sel_rd_w;
      rd_data_d = sel_data_w;
    end
    drained_d = halted && !(|valid_w) && !rd_we_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wait_q    <= '0;
      rd_we_q   <= 1'b0;
      rd_num_q  <= '0;
      rd_data_q <= '0;
      drained_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      rd_we_q   <= rd_we_d;
      rd_num_q  <= rd_num_d;
      rd_data_q <= rd_data_d;
      drained_q <= drained_d;
    end
  end

  assign rd_we   = rd_we_q;
  assign rd_num  = rd_num_q;
  assign rd_data = rd_data_q;
  assign drained = drained_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed self-checking bench for wb_arbiter (STARVE_LIMIT = 4).
// Revision : 1.0
// ============================================================================
module tb_wb_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_b;
  logic            alu_valid, ld_valid, mdu_valid;
  logic            alu_ready, ld_ready, mdu_ready;
  logic [4:0]      alu_rd, ld_rd, mdu_rd;
  logic [XLEN-1:0] alu_data, ld_data, mdu_data;
  logic [4:0]      rd_num;
  logic [XLEN-1:0] rd_data;
  logic            rd_we;
  logic            halted;
  logic            drained;

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_rd    (mdu_rd),
    .mdu_data  (mdu_data),
    .rd_num    (rd_num),
    .rd_data   (rd_data),
    .rd_we     (rd_we),
    .halted    (halted),
    .drained   (drained)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Returns 1 time unit after the rising edge; inputs change here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b     = 1'b0;
    halted    = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;

    #2;
    chk("rst_we",      rd_we,     1'b0);
    chk("rst_num",     rd_num,    5'd0);
    chk("rst_data",    rd_data,   32'h0);
    chk("rst_drained", drained,   1'b0);
    chk("rst_alu_rdy", alu_ready, 1'b0);
    #10 rst_b = 1'b1;
    next_cycle();

    // ALU alone
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1;
    chk("alu_rdy", alu_ready, 1'b1);
    chk("alu_ld_rdy", ld_ready, 1'b0);
    chk("alu_mdu_rdy", mdu_ready, 1'b0);
    next_cycle();
    alu_valid = 1'b0;
    #1;
    chk("alu_we",   rd_we,   1'b1);
    chk("alu_num",  rd_num,  5'd5);
    chk("alu_data", rd_data, 32'h0000_1234);
    chk("alu_rdy_idle", alu_ready, 1'b0);
    next_cycle();
    #1;
    chk("alu_we_off", rd_we, 1'b0);
    chk("alu_num_hold", rd_num, 5'd5);

    // All three valid together
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA;
    ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'hB;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'hC;
    #1;
    chk("tri_c0_alu", alu_ready, 1'b1);
    chk("tri_c0_ld",  ld_ready,  1'b0);
    chk("tri_c0_mdu", mdu_ready, 1'b0);
    next_cycle();
    alu_valid = 1'b0;
    #1;
    chk("tri_c1_we",   rd_we,   1'b1);
    chk("tri_c1_num",  rd_num,  5'd1);
    chk("tri_c1_data", rd_data, 32'hA);
    chk("tri_c1_ld",   ld_ready,  1'b1);
    chk("tri_c1_mdu",  mdu_ready, 1'b0);
    next_cycle();
    ld_valid = 1'b0;
    #1;
    chk("tri_c2_num",  rd_num,  5'd2);
    chk("tri_c2_data", rd_data, 32'hB);
    chk("tri_c2_mdu",  mdu_ready, 1'b1);
    next_cycle();
    mdu_valid = 1'b0;
    #1;
    chk("tri_c3_we",   rd_we,   1'b1);
    chk("tri_c3_num",  rd_num,  5'd3);
    chk("tri_c3_data", rd_data, 32'hC);
    next_cycle();
    #1;
    chk("tri_c4_we", rd_we, 1'b0);

    // Starvation: MDU becomes urgent in cycle 4
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'd100;
    mdu_valid = 1'b1; mdu_rd = 5'd7;  mdu_data = 32'h77;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("starve_alu_rdy", alu_ready, (c != 4));
      chk("starve_mdu_rdy", mdu_ready, (c == 4));
      if (c > 0) chk("starve_alu_num", rd_num, 5'(10 + c - 1));
      next_cycle();
      if (c < 4) begin
        alu_rd   = 5'(10 + c + 1);
        alu_data = 32'(100 + c + 1);
      end else begin
        mdu_valid = 1'b0;
      end
    end
    #1;
    chk("starve_c5_we",   rd_we,   1'b1);
    chk("starve_c5_num",  rd_num,  5'd7);
    chk("starve_c5_data", rd_data, 32'h77);
    chk("starve_c5_alu",  alu_ready, 1'b1);
    next_cycle();
    alu_valid = 1'b0;
    #1;
    chk("starve_c6_num",  rd_num,  5'd14);
    chk("starve_c6_data", rd_data, 32'd104);
    next_cycle();

    // Write to r0 is accepted but never enabled
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFF_FFFF;
    #1;
    chk("r0_ld_rdy", ld_ready, 1'b1);
    next_cycle();
    ld_valid = 1'b0;
    #1;
    chk("r0_we", rd_we, 1'b0);
    next_cycle();

    // Reset mid-operation clears the LD wait counter
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'h44;
    #1;
    chk("mrst_alu_rdy", alu_ready, 1'b1);
    chk("mrst_ld_rdy",  ld_ready,  1'b0);
    next_cycle();
    alu_rd = 5'd6; alu_data = 32'h66;
    #1;
    chk("mrst_pre_we", rd_we, 1'b1);
    rst_b = 1'b0;
    #1;
    chk("mrst_we",   rd_we,   1'b0);
    chk("mrst_num",  rd_num,  5'd0);
    chk("mrst_data", rd_data, 32'h0);
    rst_b = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("mrst_ld_age",  ld_ready,  (c == 4));
      chk("mrst_alu_age", alu_ready, (c != 4));
      if (c < 4) begin
        next_cycle();
        #1;
      end
    end
    next_cycle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    #1;
    chk("mrst_ld_we",   rd_we,   1'b1);
    chk("mrst_ld_num",  rd_num,  5'd4);
    chk("mrst_ld_data", rd_data, 32'h44);
    next_cycle();

    // Halt drain sequencing
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
    halted    = 1'b1;
    #1;
    chk("halt_mdu_rdy", mdu_ready, 1'b1);
    chk("halt_c0_drn",  drained,   1'b0);
    next_cycle();
    mdu_valid = 1'b0;
    #1;
    chk("halt_c1_we",  rd_we,   1'b1);
    chk("halt_c1_num", rd_num,  5'd9);
    chk("halt_c1_drn", drained, 1'b0);
    next_cycle();
    #1;
    chk("halt_c2_we",  rd_we,   1'b0);
    chk("halt_c2_drn", drained, 1'b0);
    next_cycle();
    #1;
    chk("halt_c3_drn", drained, 1'b1);
    halted = 1'b0;
    next_cycle();
    #1;
    chk("halt_c4_drn", drained, 1'b0);
    halted = 1'b1;
    next_cycle();
    #1;
    chk("halt_c5_drn", drained, 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
    next_cycle();
    alu_valid = 1'b0;
    #1;
    chk("halt_valid_drn", drained, 1'b0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
